// File: rtl/screen_fill_dma.sv
// Screen fill DMA: writes alternating fill patterns over a band of scanlines,
// giving the screen memory port to the CPU on any cycle it asks for it.
module screen_fill_dma #(
    parameter int WORDS_PER_ROW = 32,
    parameter int NUM_ROWS      = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] pattern_a,
    input  logic [15:0] pattern_b,
    input  logic [7:0]  start_row,
    input  logic [8:0]  row_count,
    input  logic        cpu_req,
    input  logic        cpu_load,
    input  logic [12:0] cpu_address,
    input  logic [15:0] cpu_in,
    output logic        scr_load,
    output logic [12:0] scr_address,
    output logic [15:0] scr_in,
    output logic        busy,
    output logic        done
);
    localparam int               COL_W    = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WORDS_PER_ROW - 1);
    localparam logic [8:0]       ROWS_MAX = 9'(NUM_ROWS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      pat_a_q, pat_a_d;
    logic [15:0]      pat_b_q, pat_b_d;
    logic [7:0]       row_q, row_d;
    logic [8:0]       rows_left_q, rows_left_d;
    logic             rel_odd_q, rel_odd_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [8:0]       count_clamped_s;
    logic             dma_write_s;
    logic [12:0]      dma_addr_s;
    logic [15:0]      dma_data_s;

    assign busy = busy_q;
    assign done = done_q;

    // Row-major screen address; 13-bit arithmetic gives the mod-8192 wrap for free.
    assign dma_addr_s      = 13'(row_q) * 13'(WORDS_PER_ROW) + 13'(col_q);
    assign dma_data_s      = rel_odd_q ? pat_b_q : pat_a_q;
    assign count_clamped_s = (row_count > ROWS_MAX) ? ROWS_MAX : row_count;

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pat_a_q     <= 16'h0000;
            pat_b_q     <= 16'h0000;
            row_q       <= 8'd0;
            rows_left_q <= 9'd0;
            rel_odd_q   <= 1'b0;
            col_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pat_a_q     <= pat_a_d;
            pat_b_q     <= pat_b_d;
            row_q       <= row_d;
            rows_left_q <= rows_left_d;
            rel_odd_q   <= rel_odd_d;
            col_q       <= col_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic: latch on start, step one word per free RUN cycle.
    always_comb begin
        state_d     = state_q;
        pat_a_d     = pat_a_q;
        pat_b_d     = pat_b_q;
        row_d       = row_q;
        rows_left_d = rows_left_q;
        rel_odd_d   = rel_odd_q;
        col_d       = col_q;
        dma_write_s = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    pat_a_d     = pattern_a;
                    pat_b_d     = pattern_b;
                    row_d       = start_row;
                    rows_left_d = count_clamped_s;
                    rel_odd_d   = 1'b0;
                    col_d       = '0;
                    if (count_clamped_s == 9'd0) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (cpu_req) begin
                    // CPU owns the port this cycle; every counter holds.
                    state_d = RUN;
                end else begin
                    dma_write_s = 1'b1;
                    if (col_q == COL_LAST) begin
                        col_d       = '0;
                        row_d       = row_q + 8'd1;
                        rel_odd_d   = ~rel_odd_q;
                        rows_left_d = rows_left_q - 9'd1;
                        if (rows_left_q == 9'd1) begin
                            state_d = DONE;
                        end else begin
                            state_d = RUN;
                        end
                    end else begin
                        col_d   = col_q + COL_W'(1);
                        state_d = RUN;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // Screen port mux: CPU first, then DMA, else idle with CPU address for reads.
    always_comb begin
        scr_load    = 1'b0;
        scr_address = cpu_address;
        scr_in      = cpu_in;
        if (cpu_req) begin
            scr_load    = cpu_load;
            scr_address = cpu_address;
            scr_in      = cpu_in;
        end else if (dma_write_s) begin
            scr_load    = 1'b1;
            scr_address = dma_addr_s;
            scr_in      = dma_data_s;
        end else begin
            scr_load    = 1'b0;
            scr_address = cpu_address;
            scr_in      = cpu_in;
        end
    end

endmodule

// File: tb/tb_screen_fill_dma.sv
// Randomized bench for screen_fill_dma: expected write streams are built from
// row/column arithmetic and compared word by word against the screen port.
module tb_screen_fill_dma;
    localparam int W  = 32;
    localparam int NR = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, abort;
    logic [15:0] pattern_a, pattern_b;
    logic [7:0]  start_row;
    logic [8:0]  row_count;
    logic        cpu_req, cpu_load;
    logic [12:0] cpu_address;
    logic [15:0] cpu_in;
    logic        scr_load;
    logic [12:0] scr_address;
    logic [15:0] scr_in;
    logic        busy, done;

    int checks   = 0;
    int failures = 0;

    logic [12:0] exp_addr[$];
    logic [15:0] exp_data[$];

    screen_fill_dma #(.WORDS_PER_ROW(W), .NUM_ROWS(NR)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .pattern_a(pattern_a), .pattern_b(pattern_b),
        .start_row(start_row), .row_count(row_count),
        .cpu_req(cpu_req), .cpu_load(cpu_load),
        .cpu_address(cpu_address), .cpu_in(cpu_in),
        .scr_load(scr_load), .scr_address(scr_address), .scr_in(scr_in),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called right after a falling edge; returns right after a falling edge.
    // stall_mode: 0 none, 1 random CPU stalls, 2 fixed 5-cycle CPU write burst.
    task automatic run_fill(input logic [15:0] pa, input logic [15:0] pb,
                            input logic [7:0] sr, input logic [8:0] rc,
                            input int stall_mode, input int abort_at, input int reset_at);
        int n, writes, stalls, cyc, burst, outcome, budget;
        n = (int'(rc) > NR) ? NR : int'(rc);
        exp_addr.delete();
        exp_data.delete();
        for (int r = 0; r < n; r++) begin
            for (int c = 0; c < W; c++) begin
                exp_addr.push_back(13'((((int'(sr) + r) % 256) * W + c) % 8192));
                exp_data.push_back((r % 2 == 1) ? pb : pa);
            end
        end

        start = 1'b1; abort = 1'b0; cpu_req = 1'b0;
        pattern_a = pa; pattern_b = pb; start_row = sr; row_count = rc;
        cpu_load = 1'b0; cpu_address = 13'($urandom); cpu_in = 16'($urandom);
        #1;
        check_eq("idle_busy", 32'(busy), 32'd0);
        check_eq("idle_load", 32'(scr_load), 32'd0);
        @(negedge clk);

        writes = 0; stalls = 0; cyc = 0; burst = 0; outcome = -1;
        budget = n * W + 200;
        while (outcome < 0 && cyc < budget) begin
            start = 1'(($urandom % 2));
            pattern_a = 16'($urandom); pattern_b = 16'($urandom);
            start_row = 8'($urandom); row_count = 9'($urandom);
            abort = 1'b0; cpu_req = 1'b0;
            cpu_load = 1'(($urandom % 2)); cpu_address = 13'($urandom); cpu_in = 16'($urandom);
            if (stall_mode == 1 && exp_addr.size() > 0 && $urandom_range(0, 7) == 0) cpu_req = 1'b1;
            if (stall_mode == 2 && writes == 100 && burst < 5) begin
                cpu_req = 1'b1; cpu_load = 1'b1; cpu_address = 13'h0100; cpu_in = 16'h1234;
                burst++;
            end
            if (abort_at >= 0 && writes == abort_at) begin
                cpu_req = 1'b0; abort = 1'b1;
            end
            if (reset_at >= 0 && writes == reset_at) begin
                cpu_req = 1'b0; reset = 1'b1;
            end
            #1;
            if (reset) begin
                check_eq("rst_busy", 32'(busy), 32'd0);
                check_eq("rst_done", 32'(done), 32'd0);
                check_eq("rst_load", 32'(scr_load), 32'd0);
                outcome = 2;
            end else if (abort) begin
                check_eq("abort_load", 32'(scr_load), 32'd0);
                check_eq("abort_addr", 32'(scr_address), 32'(cpu_address));
                check_eq("abort_busy", 32'(busy), 32'd1);
                outcome = 1;
            end else if (cpu_req) begin
                check_eq("pass_load", 32'(scr_load), 32'(cpu_load));
                check_eq("pass_addr", 32'(scr_address), 32'(cpu_address));
                check_eq("pass_in", 32'(scr_in), 32'(cpu_in));
                check_eq("stall_busy", 32'(busy), 32'd1);
                stalls++;
            end else if (exp_addr.size() > 0) begin
                check_eq("run_busy", 32'(busy), 32'd1);
                check_eq("run_done", 32'(done), 32'd0);
                check_eq("wr_load", 32'(scr_load), 32'd1);
                check_eq("wr_addr", 32'(scr_address), 32'(exp_addr[0]));
                check_eq("wr_data", 32'(scr_in), 32'(exp_data[0]));
                void'(exp_addr.pop_front());
                void'(exp_data.pop_front());
                writes++;
            end else begin
                check_eq("fin_done", 32'(done), 32'd1);
                check_eq("fin_busy", 32'(busy), 32'd0);
                check_eq("fin_load", 32'(scr_load), 32'd0);
                check_eq("fin_addr", 32'(scr_address), 32'(cpu_address));
                check_eq("fin_cycles", 32'(cyc), 32'(n * W + stalls));
                outcome = 0;
            end
            @(negedge clk);
            cyc++;
        end
        if (outcome < 0) check_eq("timeout", 32'd0, 32'd1);

        start = 1'b0; abort = 1'b0; cpu_req = 1'b0;
        if (outcome == 2) begin
            cpu_req = 1'b1; cpu_load = 1'b1; cpu_address = 13'h1555; cpu_in = 16'hBEEF;
            #1;
            check_eq("rst_pass_load", 32'(scr_load), 32'd1);
            check_eq("rst_pass_addr", 32'(scr_address), 32'h1555);
            check_eq("rst_pass_in", 32'(scr_in), 32'hBEEF);
            @(negedge clk);
            cpu_req = 1'b0;
            #1;
            check_eq("rst_hold_load", 32'(scr_load), 32'd0);
            check_eq("rst_hold_busy", 32'(busy), 32'd0);
            @(negedge clk);
        end else begin
            #1;
            check_eq("post_busy", 32'(busy), 32'd0);
            check_eq("post_done", 32'(done), 32'd0);
            check_eq("post_load", 32'(scr_load), 32'd0);
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        pattern_a = 16'h0000; pattern_b = 16'h0000; start_row = 8'd0; row_count = 9'd0;
        cpu_req = 1'b0; cpu_load = 1'b0; cpu_address = 13'h0ABC; cpu_in = 16'h0000;
        repeat (3) @(negedge clk);
        #1;
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_done", 32'(done), 32'd0);
        check_eq("reset_load", 32'(scr_load), 32'd0);
        check_eq("reset_addr", 32'(scr_address), 32'h0ABC);
        @(negedge clk);
        reset = 1'b0;

        run_fill(16'hFFFF, 16'hFFFF, 8'd0, 9'd256, 0, -1, -1);
        run_fill(16'hAAAA, 16'h5555, 8'd254, 9'd4, 0, -1, -1);
        run_fill(16'h1111, 16'h2222, 8'd7, 9'd0, 0, -1, -1);
        run_fill(16'($urandom), 16'($urandom), 8'($urandom), 9'd300, 0, -1, -1);
        run_fill(16'hC0DE, 16'hFACE, 8'd3, 9'd8, 2, -1, -1);
        run_fill(16'h0F0F, 16'hF0F0, 8'd20, 9'd5, 0, 40, -1);
        run_fill(16'h1357, 16'h2468, 8'd100, 9'd2, 0, -1, -1);

        // Abort held with start in IDLE must keep the block idle.
        start = 1'b1; abort = 1'b1; row_count = 9'd4; cpu_req = 1'b0;
        #1;
        check_eq("idle_abort_busy0", 32'(busy), 32'd0);
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        #1;
        check_eq("idle_abort_busy1", 32'(busy), 32'd0);
        check_eq("idle_abort_done", 32'(done), 32'd0);
        check_eq("idle_abort_load", 32'(scr_load), 32'd0);
        @(negedge clk);

        run_fill(16'h7777, 16'h8888, 8'd50, 9'd6, 0, -1, 50);
        reset = 1'b0;
        run_fill(16'h3C3C, 16'hC3C3, 8'd10, 9'd1, 0, -1, -1);

        for (int i = 0; i < 10; i++) begin
            run_fill(16'($urandom), 16'($urandom), 8'($urandom),
                     9'($urandom_range(0, 6)), 1, -1, -1);
        end
        run_fill(16'($urandom), 16'($urandom), 8'd255, 9'd3, 1, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/screen_fill_dma.md
SCREEN_FILL_DMA -- requirements
Module: screen_fill_dma

Interface
REQ-001 Parameter WORDS_PER_ROW, default 32, SHALL set the 16-bit words per scanline (512 px / 16).
REQ-002 Parameter NUM_ROWS, default 256, SHALL set the scanlines per frame.
REQ-003 clk  input  1  SHALL be the single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 start  input  1  SHALL be the fill request strobe, sampled in IDLE only.
REQ-006 abort  input  1  SHALL be the cancel request for a fill in progress.
REQ-007 pattern_a  input  16  SHALL be the fill word for even relative rows.
REQ-008 pattern_b  input  16  SHALL be the fill word for odd relative rows.
REQ-009 start_row  input  8  SHALL be the first scanline to fill.
REQ-010 row_count  input  9  SHALL be the number of scanlines to fill.
REQ-011 cpu_req  input  1  SHALL flag a CPU access to the screen region this cycle.
REQ-012 cpu_load, cpu_address[12:0], cpu_in[15:0]  input  SHALL be the CPU screen-port signals.
REQ-013 scr_load, scr_address[12:0], scr_in[15:0]  output  SHALL drive the screen memory port (load/address/in).
REQ-014 busy  output  1  SHALL be high in RUN.
REQ-015 done  output  1  SHALL pulse high for one cycle on fill completion.

Function
REQ-016 States SHALL be IDLE, RUN, DONE; DONE lasts exactly one cycle, then IDLE.
REQ-017 In IDLE, start=1 and abort=0 SHALL latch pattern_a, pattern_b, start_row and min(row_count, NUM_ROWS), clear col and the relative row index, and enter RUN (or DONE if the latched count is 0).
REQ-018 start SHALL be ignored in RUN and DONE; input changes after latching SHALL not affect the fill.
REQ-019 In RUN with cpu_req=0 and abort=0, one write SHALL issue per cycle: scr_load=1, scr_address=row*WORDS_PER_ROW+col (mod 8192), scr_in=pattern_a if the relative row index is even, else pattern_b.
REQ-020 col SHALL advance 0..WORDS_PER_ROW-1; on wrap, row increments (255 wraps to 0), relative index increments and rows_left decrements.
REQ-021 After the write of the last word of the last row, the next state SHALL be DONE (done=1, busy=0).
REQ-022 When cpu_req=1, scr_load/scr_address/scr_in SHALL equal cpu_load/cpu_address/cpu_in combinationally (zero latency), and all DMA counters SHALL hold.
REQ-023 When cpu_req=0 and no DMA write issues, scr_load SHALL be 0 and scr_address SHALL equal cpu_address so CPU reads remain valid.
REQ-024 abort=1 in RUN SHALL suppress that cycle's write and return to IDLE next cycle without a done pulse; abort in IDLE SHALL override start.
REQ-025 A fill of N rows with S stall cycles SHALL complete in N*WORDS_PER_ROW+S cycles from RUN entry, with done on the following cycle.

Reset
REQ-026 Asserting reset at any time, including mid-fill, SHALL force IDLE, busy=0, done=0, and all counters and latches to 0, and SHALL suppress DMA writes; the CPU passthrough remains active.
REQ-027 After reset deasserts, the block SHALL accept start on the first clock edge.

Verification
REQ-028 start_row=0, row_count=256, pattern_a=16'hFFFF, pattern_b=16'hFFFF, cpu_req=0 -> 8192 writes to addresses 0..8191, all 16'hFFFF; done exactly once, 8192 cycles after RUN entry.
REQ-029 start_row=254, row_count=4, pattern_a=16'hAAAA, pattern_b=16'h5555 -> rows 254, 255, 0, 1 written with AAAA, 5555, AAAA, 5555; 128 writes; no other address touched.
REQ-030 row_count=0 -> no scr_load from DMA, done pulses the cycle after start, busy never rises; row_count=300 -> exactly 8192 writes.
REQ-031 Mid-fill, hold cpu_req=1 for 5 cycles with cpu_load=1, cpu_address=13'h0100, cpu_in=16'h1234 -> the screen port carries the CPU write; DMA resumes at the same word; completion is 5 cycles later.
REQ-032 abort after 40 writes -> no write on the abort cycle, IDLE next cycle, no done, busy=0; a new start is then accepted.
REQ-033 Assert reset mid-fill, then release -> busy=0, done=0, no further DMA writes; a fresh start_row=10, row_count=1 writes exactly addresses 320..351.
